// File: rtl/inverter_checker.sv
// Response monitor for an inverter netlist: after each stimulus change it waits a
// settle window, then checks resp == ~stim every cycle with saturating counters.
module inverter_checker #(
  parameter int unsigned SETTLE = 2,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             clr,
  input  logic             stim,
  input  logic             resp,
  output logic [1:0]       state,
  output logic             err,
  output logic [CNT_W-1:0] check_cnt,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic             pass
);

  localparam int unsigned SET_W = 4;
  localparam logic [SET_W-1:0] SETTLE_LD = SET_W'(SETTLE);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t           cur_state;
  state_t           nxt_state;
  logic [SET_W-1:0] settle_q;
  logic [SET_W-1:0] settle_d;
  logic             stim_q;
  logic             stim_prev;
  logic             resp_q;
  logic             chg;
  logic             do_cmp;
  logic             miss;

  // Input sampling and change detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stim_q    <= 1'b0;
      stim_prev <= 1'b0;
      resp_q    <= 1'b0;
    end else begin
      stim_q    <= stim;
      stim_prev <= stim_q;
      resp_q    <= resp;
    end
  end

  assign chg  = stim_q != stim_prev;
  assign miss = resp_q != ~stim_q;

  // State and settle counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state <= IDLE;
      settle_q  <= '0;
    end else begin
      cur_state <= nxt_state;
      settle_q  <= settle_d;
    end
  end

  // Next state: enable drop beats a change, a change beats settle expiry
  always_comb begin
    nxt_state = cur_state;
    settle_d  = settle_q;
    do_cmp    = 1'b0;
    case (cur_state)
      IDLE: begin
        if (enable) begin
          nxt_state = WAIT;
          settle_d  = SETTLE_LD;
        end
      end
      WAIT: begin
        if (!enable) begin
          nxt_state = IDLE;
        end else if (chg) begin
          settle_d = SETTLE_LD;
        end else if (settle_q == SET_W'(1)) begin
          nxt_state = CHECK;
        end else begin
          settle_d = settle_q - SET_W'(1);
        end
      end
      CHECK: begin
        if (!enable) begin
          nxt_state = IDLE;
        end else if (chg) begin
          nxt_state = WAIT;
          settle_d  = SETTLE_LD;
        end else begin
          do_cmp = 1'b1;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  // Saturating counters and sticky error; clr overrides a same-cycle compare
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      check_cnt    <= '0;
      mismatch_cnt <= '0;
      err          <= 1'b0;
    end else if (clr) begin
      check_cnt    <= '0;
      mismatch_cnt <= '0;
      err          <= 1'b0;
    end else if (do_cmp) begin
      if (check_cnt != CNT_MAX) check_cnt <= check_cnt + CNT_W'(1);
      if (miss) begin
        err <= 1'b1;
        if (mismatch_cnt != CNT_MAX) mismatch_cnt <= mismatch_cnt + CNT_W'(1);
      end
    end
  end

  assign state = cur_state;
  assign pass  = (check_cnt != '0) && !err;

endmodule
